// File: rtl/obf_cell_array_seq.sv
// Key-programmable camouflage cell array: serial shadow-key load with atomic
// commit and optional lock, feeding a LATENCY-deep registered datapath.

module obf_cell_lane (
  input  logic [1:0] code,
  input  logic       din,
  output logic       dout
);
  always_comb begin
    case (code)
      2'b00:   dout = din;
      2'b01:   dout = ~din;
      2'b10:   dout = 1'b1;
      default: dout = 1'b0;
    endcase
  end
endmodule

module obf_cell_array_seq #(
  parameter int         NUM_CELLS = 8,
  parameter int         LATENCY   = 1,
  parameter logic [1:0] RST_CODE  = 2'b11
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 key_bit,
  input  logic                                 key_valid,
  input  logic                                 key_commit,
  input  logic                                 key_lock,
  input  logic [NUM_CELLS-1:0]                 data_in,
  input  logic                                 data_valid_in,
  output logic [NUM_CELLS-1:0]                 data_out,
  output logic                                 data_valid_out,
  output logic [$clog2(2*NUM_CELLS+1)-1:0]     key_count,
  output logic                                 commit_done,
  output logic                                 load_err,
  output logic                                 locked
);
  localparam int KB = 2 * NUM_CELLS;
  localparam int KW = $clog2(KB + 1);
  localparam logic [KW-1:0] KFULL = KW'(KB);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, LOCKED} state_t;

  state_t         state, state_nxt;
  logic [KB-1:0]  shadow, shadow_nxt, active;
  logic [KW-1:0]  cnt, cnt_nxt;
  logic           err_nxt, lock_req, lock_req_nxt;

  always_comb begin
    state_nxt    = state;
    shadow_nxt   = shadow;
    cnt_nxt      = cnt;
    err_nxt      = load_err;
    lock_req_nxt = lock_req;
    case (state)
      IDLE, SHIFT: begin
        if (key_valid) begin
          if (cnt < KFULL) begin
            shadow_nxt = {shadow[KB-2:0], key_bit};
            cnt_nxt    = cnt + KW'(1);
            state_nxt  = SHIFT;
          end else begin
            err_nxt = 1'b1;
          end
        end
        // Commit sees the count after any same-cycle bit has been accepted
        if (key_commit) begin
          if (cnt_nxt == KFULL) begin
            state_nxt    = COMMIT;
            lock_req_nxt = key_lock;
          end else begin
            err_nxt    = 1'b1;
            shadow_nxt = '0;
            cnt_nxt    = '0;
            state_nxt  = IDLE;
          end
        end
      end
      COMMIT: begin
        err_nxt    = 1'b0;
        shadow_nxt = '0;
        cnt_nxt    = '0;
        state_nxt  = lock_req ? LOCKED : IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      cnt         <= '0;
      load_err    <= 1'b0;
      lock_req    <= 1'b0;
      commit_done <= 1'b0;
      active      <= {NUM_CELLS{RST_CODE}};
    end else begin
      state       <= state_nxt;
      shadow      <= shadow_nxt;
      cnt         <= cnt_nxt;
      load_err    <= err_nxt;
      lock_req    <= lock_req_nxt;
      commit_done <= (state == COMMIT);
      if (state == COMMIT) active <= shadow;
    end
  end

  assign key_count = cnt;
  assign locked    = (state == LOCKED);

  logic [NUM_CELLS-1:0]              lane_out;
  logic [LATENCY:1][NUM_CELLS-1:0]   dat_pipe;
  logic [LATENCY:1]                  vld_pipe;

  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_lane
    obf_cell_lane u_lane (
      .code (active[2*g+1 -: 2]),
      .din  (data_in[g]),
      .dout (lane_out[g])
    );
  end

  // Pipeline runs every cycle; only stage 1 sees the transform
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_pipe <= '0;
      vld_pipe <= '0;
    end else begin
      dat_pipe[1] <= lane_out;
      vld_pipe[1] <= data_valid_in;
      for (int s = 2; s <= LATENCY; s++) begin
        dat_pipe[s] <= dat_pipe[s-1];
        vld_pipe[s] <= vld_pipe[s-1];
      end
    end
  end

  assign data_out       = dat_pipe[LATENCY];
  assign data_valid_out = vld_pipe[LATENCY];
endmodule

// File: tb/tb_obf_cell_array_seq.sv
// Bench for obf_cell_array_seq: LATENCY=2 and LATENCY=1 instances share inputs;
// a per-cycle scoreboard predicts both outputs, scenario tasks check control flags.

module tb_obf_cell_array_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_bit = 1'b0, key_valid = 1'b0, key_commit = 1'b0, key_lock = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic       data_valid_in = 1'b0;

  logic [3:0] dout2, dout1, kc2, kc1;
  logic       dv2, dv1, cd2, cd1, le2, le1, lk2, lk1;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_active = 8'hFF;
  logic       hold = 1'b0;
  logic [3:0] hold_d = 4'd0;
  logic       hold_v = 1'b0;
  logic [4:0] q2[$];
  logic [4:0] q1[$];

  obf_cell_array_seq #(.NUM_CELLS(4), .LATENCY(2), .RST_CODE(2'b11)) u_dut2 (
    .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid),
    .key_commit(key_commit), .key_lock(key_lock), .data_in(data_in),
    .data_valid_in(data_valid_in), .data_out(dout2), .data_valid_out(dv2),
    .key_count(kc2), .commit_done(cd2), .load_err(le2), .locked(lk2));

  obf_cell_array_seq #(.NUM_CELLS(4), .LATENCY(1), .RST_CODE(2'b11)) u_dut1 (
    .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid),
    .key_commit(key_commit), .key_lock(key_lock), .data_in(data_in),
    .data_valid_in(data_valid_in), .data_out(dout1), .data_valid_out(dv1),
    .key_count(kc1), .commit_done(cd1), .load_err(le1), .locked(lk1));

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic [3:0] d, input logic [7:0] k);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case ({k[2*i+1], k[2*i]})
        2'b00:   r[i] = d[i];
        2'b01:   r[i] = ~d[i];
        2'b10:   r[i] = 1'b1;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // One clock: push prediction at the edge, pop/compare and drive new data at negedge
  task automatic tick();
    logic [4:0] e;
    @(posedge clk);
    if (rst) begin
      q2.delete(); q1.delete();
      q2.push_back(5'd0); q2.push_back(5'd0); q1.push_back(5'd0);
    end else begin
      q2.push_back({data_valid_in, model(data_in, m_active)});
      q1.push_back({data_valid_in, model(data_in, m_active)});
    end
    @(negedge clk);
    if (q2.size() > 0) begin
      e = q2.pop_front();
      total++;
      if ({dv2, dout2} !== e) begin
        bad++;
        $display("FAIL sb_lat2 t=%0t got=%b exp=%b", $time, {dv2, dout2}, e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      total++;
      if ({dv1, dout1} !== e) begin
        bad++;
        $display("FAIL sb_lat1 t=%0t got=%b exp=%b", $time, {dv1, dout1}, e);
      end
    end
    data_in       = hold ? hold_d : 4'($urandom);
    data_valid_in = hold ? hold_v : 1'($urandom_range(0, 1));
  endtask

  task automatic shift_bits(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_bit   = k[7-i];
      tick();
    end
    key_valid = 1'b0;
    key_bit   = 1'b0;
  endtask

  // Returns at the negedge after the COMMIT-state edge
  task automatic do_commit(input logic lk);
    key_commit = 1'b1;
    key_lock   = lk;
    tick();
    key_commit = 1'b0;
    key_lock   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; m_active = 8'hFF;
    tick(); tick();
    total++;
    if ({dout2, dv2, kc2, cd2, le2, lk2} !== 12'd0) begin
      bad++; $display("FAIL reset_state got=%b exp=0", {dout2, dv2, kc2, cd2, le2, lk2});
    end
    rst = 1'b0;
    hold = 1'b1; hold_d = 4'b1010; hold_v = 1'b1;
    data_in = hold_d; data_valid_in = hold_v;
    tick(); tick();
    total++;
    if ({dv2, dout2} !== 5'b10000) begin
      bad++; $display("FAIL reset_code_out got=%b exp=10000", {dv2, dout2});
    end
    hold = 1'b0;
  endtask

  task automatic test_commit();
    key_commit = 1'b1; tick(); key_commit = 1'b0;
    total++;
    if (le2 !== 1'b1) begin bad++; $display("FAIL idle_commit_err got=%b exp=1", le2); end
    shift_bits(8'b00_01_10_11, 8);
    total++;
    if (kc2 !== 4'd8) begin bad++; $display("FAIL count8 got=%0d exp=8", kc2); end
    do_commit(1'b0);
    total++;
    if ({cd2, kc2, le2} !== 6'b1_0000_0) begin
      bad++; $display("FAIL commit_pulse got=%b exp=100000", {cd2, kc2, le2});
    end
    m_active = 8'b00_01_10_11;
    hold = 1'b1; hold_d = 4'b0110; hold_v = 1'b1;
    data_in = hold_d; data_valid_in = hold_v;
    tick();
    total++;
    if (cd2 !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b exp=0", cd2); end
    tick();
    total++;
    if (dout2 !== 4'b0010) begin bad++; $display("FAIL mode_mix got=%b exp=0010", dout2); end
    hold = 1'b0;
  endtask

  task automatic test_short_load();
    shift_bits(8'b11_11_11_11, 5);
    key_commit = 1'b1; tick(); key_commit = 1'b0;
    total++;
    if ({le2, kc2, cd2} !== 6'b1_0000_0) begin
      bad++; $display("FAIL short_commit got=%b exp=100000", {le2, kc2, cd2});
    end
    repeat (3) tick();
    shift_bits(8'b01_01_00_10, 8);
    do_commit(1'b0);
    m_active = 8'b01_01_00_10;
    total++;
    if ({le2, cd2} !== 2'b01) begin bad++; $display("FAIL err_cleared got=%b exp=01", {le2, cd2}); end
    repeat (3) tick();
  endtask

  task automatic test_overflow();
    shift_bits(8'b10_00_01_11, 8);
    shift_bits(8'b10000000, 1);
    total++;
    if ({le2, kc2} !== 5'b1_1000) begin
      bad++; $display("FAIL overflow got=%b exp=11000", {le2, kc2});
    end
    do_commit(1'b0);
    m_active = 8'b10_00_01_11;
    total++;
    if ({le2, cd2} !== 2'b01) begin bad++; $display("FAIL overflow_commit got=%b exp=01", {le2, cd2}); end
    repeat (4) tick();
  endtask

  task automatic test_lock();
    shift_bits(8'b00_11_01_10, 8);
    do_commit(1'b1);
    m_active = 8'b00_11_01_10;
    tick();
    total++;
    if (lk2 !== 1'b1) begin bad++; $display("FAIL lock_set got=%b exp=1", lk2); end
    shift_bits(8'b00_00_00_00, 8);
    total++;
    if (kc2 !== 4'd0) begin bad++; $display("FAIL locked_count got=%0d exp=0", kc2); end
    key_commit = 1'b1; tick(); key_commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({cd2, lk2} !== 2'b01) begin
        bad++; $display("FAIL locked_commit c%0d got=%b exp=01", i, {cd2, lk2});
      end
    end
    rst = 1'b1; m_active = 8'hFF;
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (lk2 !== 1'b0) begin bad++; $display("FAIL unlock_rst got=%b exp=0", lk2); end
    repeat (3) tick();
  endtask

  task automatic test_lat1_boundary();
    hold = 1'b1; hold_d = 4'hF; hold_v = 1'b1;
    data_in = hold_d; data_valid_in = hold_v;
    shift_bits(8'h00, 8);
    do_commit(1'b0);
    total++;
    if (dout1 !== 4'h0) begin bad++; $display("FAIL lat1_old_cfg got=%h exp=0", dout1); end
    m_active = 8'h00;
    tick();
    total++;
    if (dout1 !== 4'hF) begin bad++; $display("FAIL lat1_new_cfg got=%h exp=f", dout1); end
    total++;
    if (dout2 !== 4'h0) begin bad++; $display("FAIL lat2_old_cfg got=%h exp=0", dout2); end
    tick();
    total++;
    if (dout2 !== 4'hF) begin bad++; $display("FAIL lat2_new_cfg got=%h exp=f", dout2); end
    hold = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_commit();
    test_short_load();
    test_overflow();
    test_lock();
    test_lat1_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/obf_cell_array_seq.md
Name: obf_cell_array_seq

Overview:
- Parametrised, sequential successor to the combinational 2-bit-keyed camouflage cell used on obfuscated netlist nets.
- Holds NUM_CELLS key-programmable cells. Each cell applies pass, invert, force-1 or force-0 to one net.
- The key is loaded serially into a shadow register and committed atomically. It can be locked until reset.
- Data passes through a LATENCY-deep register pipeline. Sits between the key-delivery logic and the obfuscated logic cone.

Parameters:
- NUM_CELLS, 8, number of obfuscated nets / cells (1..64).
- LATENCY, 1, data pipeline depth in cycles (1..4).
- RST_CODE, 2'b11, per-cell mode code loaded into the active config on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset.
- key_bit  in  1  serial key bit.
- key_valid  in  1  key_bit is valid this cycle.
- key_commit  in  1  request transfer of shadow key to active config.
- key_lock  in  1  sampled with key_commit; if 1, block enters LOCKED after the commit.
- data_in  in  NUM_CELLS  nets to transform.
- data_valid_in  in  1  data_in valid.
- data_out  out  NUM_CELLS  transformed nets.
- data_valid_out  out  1  data_valid_in delayed by LATENCY.
- key_count  out  $clog2(2*NUM_CELLS+1)  key bits accepted since the last clear.
- commit_done  out  1  one-cycle pulse when the active config is updated.
- load_err  out  1  sticky error flag, cleared by rst or by a successful commit.
- locked  out  1  high in LOCKED.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: data_out=0, data_valid_out=0, all pipeline stages invalid/0, key_count=0, commit_done=0, load_err=0, locked=0, shadow=0, every cell's active code=RST_CODE, state=IDLE.
- Mode code per cell i: code = active[2i+1:2i].
  - 00: out=in
  - 01: out=~in
  - 10: out=1
  - 11: out=0
- Shift order: shadow shifts left, new bit enters bit 0. After 2*NUM_CELLS bits, the first bit loaded is the MSB. The first two bits loaded therefore form the code of cell NUM_CELLS-1, first bit = code[1].
- Datapath: stage 1 captures f(data_in, active config) and data_valid_in. Stages 2..LATENCY are plain delays. data_out and data_valid_out are the last stage. Latency is exactly LATENCY cycles.
- The pipeline advances every cycle regardless of valid. Data captured in a cycle uses the active config in effect that cycle; a commit affects captures from the next cycle on.
- FSM IDLE:
  - key_valid: shift in, key_count=1, go to SHIFT.
  - key_commit with key_count=0: load_err=1, stay in IDLE.
- FSM SHIFT:
  - key_valid with key_count<2N: shift in, key_count+1.
  - key_valid with key_count==2N: bit ignored, load_err=1.
  - key_commit: evaluated after any same-cycle bit is accepted. If the resulting count==2N, go to COMMIT. Otherwise load_err=1, shadow=0, key_count=0, go to IDLE.
- FSM COMMIT (1 cycle):
  - active <= shadow, commit_done=1, load_err=0, shadow=0, key_count=0.
  - Go to LOCKED if key_lock was high on the commit cycle, else IDLE.
  - key_valid during COMMIT is ignored.
- FSM LOCKED: locked=1. key_valid, key_commit and key_lock are ignored, key_count stays 0, active config frozen. Only rst exits.
- rst mid-shift or in LOCKED returns everything to reset values, including active=RST_CODE. The in-flight pipeline is flushed to 0/invalid.
- key_lock without key_commit has no effect.

Test Plan (NUM_CELLS=4, LATENCY=2 unless noted):
- Reset then data_in=4'b1010, valid=1 -> data_out=4'b0000 (RST_CODE=11) two cycles later, data_valid_out=1.
- Shift 8 bits 00_01_10_11 (first bit first), commit -> commit_done pulse. Then data_in=4'b0110 -> data_out[3]=0 (pass), [2]=0 (inv of 1), [1]=1 (force-1), [0]=0 (force-0), i.e. 4'b0010 at +2 cycles.
- Shift 5 bits, commit -> load_err=1, key_count=0, active config unchanged. A subsequent full 8-bit load and commit -> load_err=0.
- Shift 8 bits, then a 9th bit -> load_err=1, key_count stays 8. Commit -> succeeds, load_err clears, active holds the first 8 bits.
- Commit with key_lock=1 -> locked=1. A further 8-bit load and commit -> no commit_done, data_out unchanged. rst -> locked=0, config=RST_CODE.
- LATENCY=1: commit with data_valid_in held and data_in=4'hF -> output reflects the old config up to and including the capture in the COMMIT cycle, and the new config from the next capture onward.
